// File: rtl/counter_sched_4.sv
// counter_sched_4: round-robin scheduler for one shared 4-bit loadable
// up-counter. Two requesters each ask for an N-cycle delay. The block
// arbitrates between them, loads the counter with (16 - N) mod 16, counts
// until carry-out, and then pulses done to the requester it served.
//
// Ports:
//   CLK          clock, rising edge
//   Clr          synchronous active-high reset
//   req0/req1    level requests, sampled only while idle
//   dur0/dur1    requested delay N (0 means 16), captured at grant
//   hold         pauses counting while running
//   cnt_A        counter value (monitor only)
//   cnt_CO       counter carry-out (Count & A == 15)
//   Load/Count   counter load / count enables
//   IN           counter parallel-load data
//   gnt0/gnt1    requester currently being served
//   done0/done1  one-cycle completion pulse
//   busy         scheduler not idle
module counter_sched_4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] dur0,
    input  logic [WIDTH-1:0] dur1,
    input  logic             hold,
    input  logic [WIDTH-1:0] cnt_A,
    input  logic             cnt_CO,
    output logic             Load,
    output logic             Count,
    output logic [WIDTH-1:0] IN,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic             owner;
    logic             ptr;
    logic [WIDTH-1:0] start;

    logic             win;
    logic [WIDTH-1:0] dur_win;
    logic [WIDTH-1:0] start_new;

    // The counter value is observed for debug only; nothing depends on it.
    logic unused_cnt_a;
    assign unused_cnt_a = ^cnt_A;

    // Arbitration: a lone requester wins; on a tie the pointer decides.
    always_comb begin
        win       = (req0 & req1) ? ptr : req1;
        dur_win   = win ? dur1 : dur0;
        // Two's complement start value; dur 0 wraps to start 0, i.e. 16 counts.
        start_new = {WIDTH{1'b0}} - dur_win;
    end

    // Scheduler state and registered Moore outputs.
    always_ff @(posedge CLK) begin
        if (Clr) begin
            state <= IDLE;
            owner <= 1'b0;
            ptr   <= 1'b0;
            start <= '0;
            Load  <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= 1'b0;
        end else begin
            Load  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        state <= LOAD;
                        owner <= win;
                        start <= start_new;
                        Load  <= 1'b1;
                        busy  <= 1'b1;
                        gnt0  <= ~win;
                        gnt1  <= win;
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    if (cnt_CO) begin
                        state <= DONE;
                        done0 <= ~owner;
                        done1 <= owner;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ptr   <= ~owner;
                    busy  <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Count is the only combinational output, so hold freezes the counter at once.
    assign Count = (state == RUN) & ~hold;
    assign IN    = start;

endmodule

// File: tb/tb_counter_sched_4.sv
// Testbench for counter_sched_4: the shared counter is modelled beside the
// DUT, and a job-level reference model predicts every output per cycle.
module tb_counter_sched_4;

    logic       CLK = 1'b0;
    logic       Clr = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] dur0 = 4'd0;
    logic [3:0] dur1 = 4'd0;
    logic [3:0] cnt_A = 4'd0;
    logic       cnt_CO;
    logic       Load, Count, gnt0, gnt1, done0, done1, busy;
    logic [3:0] IN;

    always #5 CLK = ~CLK;

    counter_sched_4 #(.WIDTH(4)) dut (
        .CLK    (CLK),
        .Clr    (Clr),
        .req0   (req0),
        .req1   (req1),
        .dur0   (dur0),
        .dur1   (dur1),
        .hold   (hold),
        .cnt_A  (cnt_A),
        .cnt_CO (cnt_CO),
        .Load   (Load),
        .Count  (Count),
        .IN     (IN),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .busy   (busy)
    );

    // Shared 4-bit loadable counter; its clear is not driven by the scheduler.
    always @(posedge CLK) begin
        if (Load)       cnt_A <= IN;
        else if (Count) cnt_A <= cnt_A + 4'd1;
    end
    assign cnt_CO = Count & (cnt_A == 4'd15);

    // Reference model: a job is described by its age since grant, its length
    // and how many counting cycles it has consumed so far.
    bit         m_active = 1'b0;
    int         m_since  = 0;
    int         m_ran    = 0;
    int         m_n      = 0;
    bit         m_owner  = 1'b0;
    bit         m_pref   = 1'b0;
    logic [3:0] m_start  = 4'd0;
    bit         chk_en   = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit ld, running, fin;
        ld      = m_active && (m_since == 1);
        running = m_active && (m_since >= 2) && (m_ran < m_n);
        fin     = m_active && (m_since >= 2) && (m_ran == m_n);
        chk("Load",  4'(Load),  4'(ld));
        chk("Count", 4'(Count), 4'(running && !hold));
        chk("IN",    IN,        m_start);
        chk("gnt0",  4'(gnt0),  4'(m_active && !m_owner));
        chk("gnt1",  4'(gnt1),  4'(m_active && m_owner));
        chk("done0", 4'(done0), 4'(fin && !m_owner));
        chk("done1", 4'(done1), 4'(fin && m_owner));
        chk("busy",  4'(busy),  4'(m_active));
        if (running) chk("cnt_A", cnt_A, 4'(int'(m_start) + m_ran));
    endtask

    task automatic model_step(input logic r0, input logic r1, input logic [3:0] d0,
                              input logic [3:0] d1, input logic h, input logic c);
        bit running, fin;
        int n;
        if (c) begin
            m_active = 1'b0;
            m_pref   = 1'b0;
            m_start  = 4'd0;
            chk_en   = 1'b1;
            return;
        end
        if (m_active) begin
            running = (m_since >= 2) && (m_ran < m_n);
            fin     = (m_since >= 2) && (m_ran == m_n);
            if (running && !h) m_ran++;
            if (fin) begin
                m_active = 1'b0;
                m_pref   = ~m_owner;
            end
            m_since++;
        end else if (r0 || r1) begin
            m_owner  = (r0 && r1) ? m_pref : r1;
            n        = m_owner ? int'(d1) : int'(d0);
            m_n      = (n == 0) ? 16 : n;
            m_start  = 4'((16 - m_n) % 16);
            m_active = 1'b1;
            m_since  = 1;
            m_ran    = 0;
        end
    endtask

    // One clock cycle: drive inputs, check mid-cycle, advance model at the edge.
    task automatic cyc(input logic r0, input logic r1, input logic [3:0] d0,
                       input logic [3:0] d1, input logic h, input logic c);
        req0 = r0; req1 = r1; dur0 = d0; dur1 = d1; hold = h; Clr = c;
        @(negedge CLK);
        if (chk_en) check_outputs();
        @(posedge CLK);
        model_step(r0, r1, d0, d1, h, c);
        #1;
    endtask

    initial begin
        // Initial reset.
        cyc(0, 0, 4'd0, 4'd0, 0, 1);
        cyc(0, 0, 4'd0, 4'd0, 0, 1);
        cyc(0, 0, 4'd0, 4'd0, 0, 0);

        // Single job: dur0 = 3, request pulsed for one cycle.
        cyc(1, 0, 4'd3, 4'd0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 4'd3, 4'd0, 0, 0);

        // Both requesting from reset priority: alternation 0,1,0,1.
        cyc(0, 0, 4'd0, 4'd0, 0, 1);
        for (int i = 0; i < 34; i++) cyc(1, 1, 4'd2, 4'd5, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 4'd2, 4'd5, 0, 0);

        // dur = 0 means 16 counting cycles.
        cyc(0, 1, 4'd0, 4'd0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 4'd0, 4'd0, 0, 0);

        // hold for three cycles in the middle of RUN.
        cyc(1, 0, 4'd4, 4'd0, 0, 0);
        cyc(0, 0, 4'd4, 4'd0, 0, 0);
        cyc(0, 0, 4'd4, 4'd0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'd4, 4'd0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 4'd4, 4'd0, 0, 0);

        // dur and req changed mid-job are ignored.
        cyc(1, 0, 4'd5, 4'd0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 4'd5, 4'd0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 4'd9, 4'd0, 0, 0);

        // Reset mid-RUN, then a normal job.
        cyc(1, 0, 4'd7, 4'd0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'd7, 4'd0, 0, 0);
        cyc(0, 0, 4'd7, 4'd0, 0, 1);
        cyc(0, 0, 4'd7, 4'd0, 0, 1);
        cyc(0, 0, 4'd7, 4'd0, 0, 0);
        cyc(1, 0, 4'd3, 4'd0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 4'd3, 4'd0, 0, 0);

        // Randomized traffic with occasional hold and rare reset.
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom), 4'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
